// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioner: counter sizing and the
// legal synchroniser depth range.
package input_cond_pkg;

  // Legal range for the synchroniser chain depth.
  typedef enum int {
    SYNC_MIN = 2,
    SYNC_MAX = 4
  } sync_bounds_e;

  // Bits needed to hold a debounce count of 0..d.
  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_chan.sv
// One conditioned input channel: synchroniser chain, consecutive-sample
// debouncer, registered clean level and optional one-cycle edge pulses.
// Edge pulse flops exist only when INPUT_COND_EDGE_EN is defined; otherwise
// rise/fall are tied to 0.
module input_conditioner_chan
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_bypass,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CW-1:0]          cnt;
  logic [CW:0]            cnt_inc;
  logic [CW:0]            eff_d;
  logic                   differ;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Plain flop chain on the asynchronous pad input; nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Decide whether the synced sample has now differed long enough.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no
    // latch can be inferred.
    eff_d   = cfg_bypass ? (CW+1)'(1) : (CW+1)'(DEBOUNCE_CYCLES);
    cnt_inc = {1'b0, cnt} + (CW+1)'(1);
    differ  = (sync_out != clean);
    // >= rather than == so a count left over when bypass turns on is
    // discarded and the next differing sample is accepted at once.
    accept  = differ && (cnt_inc >= eff_d);
  end

  // Count consecutive differing samples; any agreeing sample restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (!differ) begin
      cnt   <= '0;
    end else if (accept) begin
      clean <= sync_out;
      cnt   <= '0;
    end else begin
      cnt   <= cnt_inc[CW-1:0];
    end
  end

`ifdef INPUT_COND_EDGE_EN
  // Pulses register on the same edge the clean level updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept &  sync_out;
      fall <= accept & ~sync_out;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner for the pad-to-core input bits. Each channel is
// synchronised, debounced and registered independently in the core clock
// domain. Define INPUT_COND_EDGE_EN to build one-cycle rise/fall pulses;
// without it in_rise/in_fall are constant 0 but the ports remain.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_INPUTS      = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_bypass,
  input  logic [NUM_INPUTS-1:0] in_raw,
  output logic [NUM_INPUTS-1:0] in_clean,
  output logic [NUM_INPUTS-1:0] in_rise,
  output logic [NUM_INPUTS-1:0] in_fall
);

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < int'(SYNC_MIN) || SYNC_STAGES > int'(SYNC_MAX)) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, int'(SYNC_MIN), int'(SYNC_MAX));
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES=%0d must be >= 1", DEBOUNCE_CYCLES);
  end
  if (NUM_INPUTS < 1) begin : g_bad_width
    $error("input_conditioner: NUM_INPUTS=%0d must be >= 1", NUM_INPUTS);
  end

  // One fully independent conditioner per pad input.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    input_conditioner_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cfg_bypass(cfg_bypass),
      .raw       (in_raw[i]),
      .clean     (in_clean[i]),
      .rise      (in_rise[i]),
      .fall      (in_fall[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (default parameters). Stimulus
// pushes the expected output change (cycle and values) into a queue; a
// monitor pops and compares whenever any output changes.
module tb_input_conditioner;

  localparam int N       = 10;
  localparam int LAT     = 18;  // 2 sync stages + 16 debounce samples
  localparam int LAT_BYP = 3;   // 2 sync stages + 1 sample in bypass

  typedef struct {
    int           cyc;
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } evt_t;

  evt_t         sb_q[$];
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_bypass = 1'b0;
  logic [N-1:0] in_raw = '0;
  logic [N-1:0] in_clean, in_rise, in_fall;
  logic [3*N-1:0] prev_out = '0;
  logic [N-1:0] exp_clean = '0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           x_seen = 0;
  bit           mon_en = 1'b0;

  input_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_bypass(cfg_bypass),
    .in_raw    (in_raw),
    .in_clean  (in_clean),
    .in_rise   (in_rise),
    .in_fall   (in_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic push_evt(input int c, input logic [N-1:0] cl, input logic [N-1:0] r,
                          input logic [N-1:0] f);
    evt_t e;
    e.cyc = c; e.clean = cl; e.rise = r; e.fall = f;
    sb_q.push_back(e);
  endtask

  // Expected clean-level change at cycle c, with its edge pulses.
  task automatic expect_change(input int c, input logic [N-1:0] nc);
`ifdef INPUT_COND_EDGE_EN
    push_evt(c, nc, nc & ~exp_clean, ~nc & exp_clean);
    push_evt(c + 1, nc, '0, '0);
`else
    push_evt(c, nc, '0, '0);
`endif
    exp_clean = nc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output change must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if ($isunknown({in_clean, in_rise, in_fall})) x_seen++;
      if ({in_clean, in_rise, in_fall} !== prev_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got cycle %0d clean %h rise %h fall %h, required no change",
                   cyc, in_clean, in_rise, in_fall);
        end else begin
          evt_t e;
          e = sb_q.pop_front();
          check("output_event", {cyc[31:0], 2'b00, in_clean, in_rise, in_fall},
                {e.cyc[31:0], 2'b00, e.clean, e.rise, e.fall});
        end
        prev_out = {in_clean, in_rise, in_fall};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset pulse with inputs low
    idle(1);
    mon_en = 1'b1;
    check("reset_state", {34'd0, in_clean, in_rise, in_fall}, 64'd0);
    idle(2);
    rst = 1'b0;
    idle(5);
    check("post_reset_idle", {34'd0, in_clean, in_rise, in_fall}, 64'd0);

    // 2: channel 0 step up, then down
    in_raw[0] = 1'b1; expect_change(cyc + LAT, exp_clean | 10'h001);
    idle(30);
    in_raw[0] = 1'b0; expect_change(cyc + LAT, exp_clean & ~10'h001);
    idle(30);

    // 3: channel 3 glitches of 10 and 15 cycles are rejected
    in_raw[3] = 1'b1; idle(10); in_raw[3] = 1'b0; idle(30);
    in_raw[3] = 1'b1; idle(15); in_raw[3] = 1'b0; idle(30);
    // exactly 16 cycles high is accepted, then falls 16 cycles later
    in_raw[3] = 1'b1; expect_change(cyc + LAT, exp_clean | 10'h008);
    idle(16);
    in_raw[3] = 1'b0; expect_change(cyc + LAT, exp_clean & ~10'h008);
    idle(30);
    // counter back at 0: a held step still takes full latency
    in_raw[3] = 1'b1; expect_change(cyc + LAT, exp_clean | 10'h008);
    idle(30);
    in_raw[3] = 1'b0; expect_change(cyc + LAT, exp_clean & ~10'h008);
    idle(30);

    // 4: channel 5 toggling 10/10 is filtered out
    for (int p = 0; p < 4; p++) begin
      in_raw[5] = 1'b1; idle(10);
      in_raw[5] = 1'b0; idle(10);
    end
    idle(20);
    // bypass: output follows the toggling 3 edges later
    cfg_bypass = 1'b1;
    idle(5);
    for (int p = 0; p < 2; p++) begin
      in_raw[5] = 1'b1; expect_change(cyc + LAT_BYP, exp_clean | 10'h020); idle(10);
      in_raw[5] = 1'b0; expect_change(cyc + LAT_BYP, exp_clean & ~10'h020); idle(10);
    end
    cfg_bypass = 1'b0;
    idle(10);
    // bypass 0->1 mid-count: pending count discarded, next sample accepted
    in_raw[5] = 1'b1;
    idle(8);
    cfg_bypass = 1'b1; expect_change(cyc + 1, exp_clean | 10'h020);
    idle(10);
    // bypass 1->0: counting restarts, full latency
    cfg_bypass = 1'b0;
    in_raw[5] = 1'b0; expect_change(cyc + LAT, exp_clean & ~10'h020);
    idle(30);

    // 5: all channels together
    in_raw = '1; expect_change(cyc + LAT, 10'h3FF);
    idle(40);
    in_raw = '0; expect_change(cyc + LAT, 10'h000);
    idle(30);

    // 6: async reset mid-count on channel 1 while channel 7 is clean high
    in_raw[7] = 1'b1; expect_change(cyc + LAT, exp_clean | 10'h080);
    idle(30);
    in_raw[1] = 1'b1;
    idle(10);
    @(posedge clk);
    #2;
    push_evt(cyc, '0, '0, '0);
    exp_clean = '0;
    rst = 1'b1;
    #1;
    check("async_reset_clear", {34'd0, in_clean, in_rise, in_fall}, 64'd0);
    idle(3);
    rst = 1'b0; expect_change(cyc + LAT, 10'h082);
    idle(30);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("no_x_on_outputs", 64'(x_seen), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
